// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input and received-byte outputs of the UART receiver.
interface uart_rx_if;
  logic       rxd;
  logic [7:0] rx_out;
  logic       rx_vld;
  logic       frame_error;
  logic       busy;
  modport master (input rxd, output rx_out, rx_vld, frame_error, busy);
  modport slave (output rxd, input rx_out, rx_vld, frame_error, busy);
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 LSB-first UART byte receiver with mid-bit sampling,
// glitch rejection on the start bit and a single error strobe per break.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input logic       clk100m,
  input logic       cpu_reset,
  uart_rx_if.master rx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shreg, shreg_n, rx_out_n;
  logic vld_n, ferr_n, rxd_s;
  // synchroniser resets to idle-high so reset release never looks like a start bit
  always_ff @(posedge clk100m or posedge cpu_reset)
    if (cpu_reset) sync_q <= '1;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], rx.rxd};
  assign rxd_s = sync_q[SYNC_STAGES-1];
  always_ff @(posedge clk100m or posedge cpu_reset)
    if (cpu_reset) begin
      state          <= IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      shreg          <= '0;
      rx.rx_out      <= '0;
      rx.rx_vld      <= 1'b0;
      rx.frame_error <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      bit_idx        <= bit_idx_n;
      shreg          <= shreg_n;
      rx.rx_out      <= rx_out_n;
      rx.rx_vld      <= vld_n;
      rx.frame_error <= ferr_n;
    end
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    rx_out_n  = rx.rx_out;
    vld_n     = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n   = '0;
        state_n = rxd_s ? IDLE : START;
      end
      START:
        if (cnt == MID) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rxd_s ? IDLE : DATA;
        end
      DATA:
        if (cnt == LAST) begin
          cnt_n            = '0;
          shreg_n[bit_idx] = rxd_s;
          bit_idx_n        = bit_idx + 3'd1;
          state_n          = (bit_idx == 3'd7) ? STOP : DATA;
        end
      STOP:
        if (cnt == LAST) begin
          cnt_n    = '0;
          rx_out_n = rxd_s ? shreg : rx.rx_out;
          vld_n    = rxd_s;
          ferr_n   = !rxd_s;
          state_n  = rxd_s ? IDLE : BRK;
        end
      BRK: begin
        cnt_n   = '0;
        state_n = rxd_s ? IDLE : BRK;
      end
      default: state_n = IDLE;
    endcase
  end
  assign rx.busy = (state != IDLE);
endmodule
